// File: rtl/psram_port_arbiter.sv
// Round-robin arbiter of NUM_PORTS CPU request ports onto one PSRAM user channel, one transaction in flight.
// Read rsp one cycle after mem_rd_valid (or after RD_TIMEOUT wait cycles); write rsp at accept+2+WRITE_CYCLES; req_ready only in IDLE.
module psram_port_arbiter #(
  parameter int NUM_PORTS    = 2,
  parameter int ADDR_WIDTH   = 21,
  parameter int DATA_WIDTH   = 32,
  parameter int WRITE_CYCLES = 14,
  parameter int RD_TIMEOUT   = 255
) (
  input  logic                                clk,
  input  logic                                reset,
  input  logic [NUM_PORTS-1:0]                req_valid,
  input  logic [NUM_PORTS-1:0]                req_we,
  input  logic [NUM_PORTS*ADDR_WIDTH-1:0]     req_addr,
  input  logic [NUM_PORTS*DATA_WIDTH-1:0]     req_wdata,
  input  logic [NUM_PORTS*(DATA_WIDTH/8)-1:0] req_be,
  output logic [NUM_PORTS-1:0]                req_ready,
  output logic [NUM_PORTS-1:0]                rsp_valid,
  output logic [DATA_WIDTH-1:0]               rsp_rdata,
  output logic                                rsp_err,
  input  logic                                mem_calib,
  output logic                                mem_cmd,
  output logic                                mem_cmd_en,
  output logic [ADDR_WIDTH-1:0]               mem_addr,
  output logic [DATA_WIDTH-1:0]               mem_wr_data,
  output logic [DATA_WIDTH/8-1:0]             mem_data_mask,
  input  logic [DATA_WIDTH-1:0]               mem_rd_data,
  input  logic                                mem_rd_valid
);

  localparam int BW      = DATA_WIDTH / 8;
  localparam int PW      = (NUM_PORTS > 1) ? $clog2(NUM_PORTS) : 1;
  localparam int CNT_MAX = (RD_TIMEOUT > WRITE_CYCLES) ? RD_TIMEOUT : WRITE_CYCLES;
  localparam int CW      = $clog2(CNT_MAX + 1);
  localparam logic [DATA_WIDTH-1:0] POISON = DATA_WIDTH'(32'hDEADBEEF);

  typedef enum logic [2:0] {
    S_INIT,
    S_IDLE,
    S_ISSUE,
    S_RD_WAIT,
    S_WR_HOLD,
    S_DONE
  } state_t;

  typedef struct packed {
    logic [PW-1:0]         port;
    logic                  we;
    logic [ADDR_WIDTH-1:0] addr;
    logic [DATA_WIDTH-1:0] wdata;
    logic [BW-1:0]         mask;
  } txn_t;

  state_t        state, state_nx;
  txn_t          cur, pick;
  logic [PW-1:0] rr, grant_idx;
  logic [PW:0]   cand;
  logic          grant_vld, accept;
  logic [CW-1:0] cnt;
  logic          rd_hit, rd_tmo;

  // Round-robin search starting just after the last granted port.
  always_comb begin
    grant_vld = 1'b0;
    grant_idx = rr;
    cand      = '0;
    for (int i = 1; i <= NUM_PORTS; i++) begin
      cand = {1'b0, rr} + (PW+1)'(i);
      if (cand >= (PW+1)'(NUM_PORTS))
        cand = cand - (PW+1)'(NUM_PORTS);
      if (!grant_vld && req_valid[cand[PW-1:0]]) begin
        grant_vld = 1'b1;
        grant_idx = cand[PW-1:0];
      end
    end
  end

  always_comb begin
    pick      = '0;
    pick.port = grant_idx;
    for (int p = 0; p < NUM_PORTS; p++) begin
      if (grant_idx == PW'(p)) begin
        pick.we    = req_we[p];
        pick.addr  = req_addr[p*ADDR_WIDTH +: ADDR_WIDTH];
        pick.wdata = req_wdata[p*DATA_WIDTH +: DATA_WIDTH];
        pick.mask  = ~req_be[p*BW +: BW];
      end
    end
  end

  assign accept = (state == S_IDLE) && mem_calib && grant_vld;

  always_ff @(posedge clk) begin
    if (reset)
      state <= S_INIT;
    else
      state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    rd_hit   = 1'b0;
    rd_tmo   = 1'b0;
    case (state)
      S_INIT:    if (mem_calib) state_nx = S_IDLE;
      S_IDLE: begin
        if (!mem_calib)
          state_nx = S_INIT;
        else if (grant_vld)
          state_nx = S_ISSUE;
      end
      S_ISSUE:   state_nx = cur.we ? S_WR_HOLD : S_RD_WAIT;
      S_RD_WAIT: begin
        // Data arriving on the timeout cycle still counts as a hit.
        if (mem_rd_valid) begin
          rd_hit   = 1'b1;
          state_nx = S_DONE;
        end else if (cnt == CW'(RD_TIMEOUT)) begin
          rd_tmo   = 1'b1;
          state_nx = S_DONE;
        end
      end
      S_WR_HOLD: if (cnt == CW'(WRITE_CYCLES)) state_nx = S_DONE;
      S_DONE:    state_nx = S_IDLE;
      default:   state_nx = S_INIT;
    endcase
  end

  always_comb begin
    req_ready     = '0;
    rsp_valid     = '0;
    mem_cmd_en    = (state == S_ISSUE);
    mem_cmd       = cur.we;
    mem_addr      = cur.addr;
    mem_wr_data   = cur.wdata;
    mem_data_mask = '1;
    for (int p = 0; p < NUM_PORTS; p++) begin
      req_ready[p] = accept && (grant_idx == PW'(p));
      rsp_valid[p] = (state == S_DONE) && (cur.port == PW'(p));
    end
    case (state)
      S_ISSUE:   mem_data_mask = cur.we ? cur.mask : '0;
      S_RD_WAIT: mem_data_mask = '0;
      default:   mem_data_mask = '1;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      rr        <= PW'(NUM_PORTS - 1);
      cur       <= '0;
      cnt       <= '0;
      rsp_rdata <= POISON;
      rsp_err   <= 1'b0;
    end else begin
      if (accept) begin
        cur     <= pick;
        rr      <= grant_idx;
        rsp_err <= 1'b0;
      end
      // cnt equals the index of the current wait/hold cycle, starting at 1.
      case (state)
        S_ISSUE:              cnt <= CW'(1);
        S_RD_WAIT, S_WR_HOLD: cnt <= cnt + 1'b1;
        default:              cnt <= '0;
      endcase
      if (rd_hit) begin
        rsp_rdata <= mem_rd_data;
        rsp_err   <= 1'b0;
      end else if (rd_tmo) begin
        rsp_rdata <= POISON;
        rsp_err   <= 1'b1;
      end
    end
  end

  a_ready_onehot: assert property (@(posedge clk) disable iff (reset) $onehot0(req_ready));
  a_rsp_onehot:   assert property (@(posedge clk) disable iff (reset) $onehot0(rsp_valid));
  a_cmd_pulse:    assert property (@(posedge clk) disable iff (reset) mem_cmd_en |=> !mem_cmd_en);

endmodule

// File: tb/tb_psram_port_arbiter.sv
// Bench for psram_port_arbiter: directed transaction table, randomized traffic against a round-robin
// model, plus timeout, calibration and mid-transaction reset sequences.
module tb_psram_port_arbiter;

  localparam int NP  = 2;
  localparam int AW  = 21;
  localparam int DW  = 32;
  localparam int BW  = DW / 8;
  localparam int WRC = 14;
  localparam int RDT = 255;
  localparam logic [DW-1:0] POISON = 32'hDEADBEEF;

  logic               clk = 1'b0;
  logic               reset;
  logic [NP-1:0]      req_valid, req_we, req_ready, rsp_valid;
  logic [NP*AW-1:0]   req_addr;
  logic [NP*DW-1:0]   req_wdata;
  logic [NP*BW-1:0]   req_be;
  logic [DW-1:0]      rsp_rdata, mem_wr_data, mem_rd_data;
  logic               rsp_err, mem_calib, mem_cmd, mem_cmd_en, mem_rd_valid;
  logic [AW-1:0]      mem_addr;
  logic [BW-1:0]      mem_data_mask;

  psram_port_arbiter #(
    .NUM_PORTS(NP), .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .WRITE_CYCLES(WRC), .RD_TIMEOUT(RDT)
  ) dut (
    .clk(clk), .reset(reset),
    .req_valid(req_valid), .req_we(req_we), .req_addr(req_addr), .req_wdata(req_wdata),
    .req_be(req_be), .req_ready(req_ready), .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata),
    .rsp_err(rsp_err), .mem_calib(mem_calib), .mem_cmd(mem_cmd), .mem_cmd_en(mem_cmd_en),
    .mem_addr(mem_addr), .mem_wr_data(mem_wr_data), .mem_data_mask(mem_data_mask),
    .mem_rd_data(mem_rd_data), .mem_rd_valid(mem_rd_valid)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic [NP-1:0]         vld;
    logic [NP-1:0]         we;
    logic [NP-1:0][AW-1:0] addr;
    logic [NP-1:0][DW-1:0] wdata;
    logic [NP-1:0][BW-1:0] be;
    int                    dly;      // read data arrives dly cycles after cmd_en; 0 = never
    logic [DW-1:0]         rdval;
    int                    exp_port;
    logic [DW-1:0]         exp_rdata;
    logic                  exp_err;
  } txn_t;

  int   tests = 0;
  int   fails = 0;
  int   m_rr  = NP - 1;
  txn_t tbl[11];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic txn_t mk(input logic [1:0] vld, input logic [1:0] we,
                              input logic [AW-1:0] a0, input logic [AW-1:0] a1,
                              input logic [DW-1:0] d0, input logic [DW-1:0] d1,
                              input logic [BW-1:0] b0, input logic [BW-1:0] b1,
                              input int dly, input logic [DW-1:0] rdval,
                              input int ep, input logic [DW-1:0] erd, input logic eerr);
    txn_t t;
    t.vld = vld; t.we = we;
    t.addr[0] = a0;  t.addr[1] = a1;
    t.wdata[0] = d0; t.wdata[1] = d1;
    t.be[0] = b0;    t.be[1] = b1;
    t.dly = dly; t.rdval = rdval;
    t.exp_port = ep; t.exp_rdata = erd; t.exp_err = eerr;
    return t;
  endfunction

  task automatic chk_reset(input string tag);
    chk({tag, ":req_ready"}, req_ready, 0);
    chk({tag, ":rsp_valid"}, rsp_valid, 0);
    chk({tag, ":rsp_err"}, rsp_err, 0);
    chk({tag, ":rsp_rdata"}, rsp_rdata, POISON);
    chk({tag, ":cmd_en"}, mem_cmd_en, 0);
    chk({tag, ":cmd"}, mem_cmd, 0);
    chk({tag, ":addr"}, mem_addr, 0);
    chk({tag, ":wr_data"}, mem_wr_data, 0);
    chk({tag, ":mask"}, mem_data_mask, 4'hF);
  endtask

  task automatic run_txn(input txn_t t, input string tag);
    int            tc, exp_cyc, n;
    logic          we, busy_bad, mask_bad;
    logic [NP-1:0] onehot;
    logic [BW-1:0] expmask;
    req_valid = t.vld; req_we = t.we; req_addr = t.addr; req_wdata = t.wdata; req_be = t.be;
    #1;
    n = 0;
    while (req_ready == '0 && n < 50) begin
      step(); #1; n++;
    end
    onehot = '0;
    onehot[t.exp_port] = 1'b1;
    chk({tag, ":grant"}, req_ready, onehot);
    if (req_ready == '0) return;
    m_rr    = t.exp_port;
    tc      = cyc;
    we      = t.we[t.exp_port];
    expmask = we ? ~t.be[t.exp_port] : '0;
    step();
    req_valid[t.exp_port] = 1'b0;
    #1;
    chk({tag, ":cmd_en"}, mem_cmd_en, 1);
    chk({tag, ":cmd"}, mem_cmd, we);
    chk({tag, ":addr"}, mem_addr, t.addr[t.exp_port]);
    chk({tag, ":issue_mask"}, mem_data_mask, expmask);
    if (we) chk({tag, ":wr_data"}, mem_wr_data, t.wdata[t.exp_port]);
    if (we)              exp_cyc = tc + 2 + WRC;
    else if (t.dly != 0) exp_cyc = tc + 2 + t.dly;
    else                 exp_cyc = tc + 2 + RDT;
    busy_bad = 1'b0; mask_bad = 1'b0; n = 0;
    do begin
      step();
      mem_rd_valid = !we && t.dly != 0 && cyc == tc + 1 + t.dly;
      mem_rd_data  = mem_rd_valid ? t.rdval : $urandom();
      #1;
      if (rsp_valid == '0) begin
        if (req_ready != '0 || mem_cmd_en) busy_bad = 1'b1;
        if (we && mem_data_mask != '1) mask_bad = 1'b1;
      end
      n++;
    end while (rsp_valid == '0 && n < 300);
    mem_rd_valid = 1'b0;
    chk({tag, ":busy_quiet"}, busy_bad, 0);
    if (we) chk({tag, ":hold_mask"}, mask_bad, 0);
    chk({tag, ":rsp_cycle"}, cyc, exp_cyc);
    chk({tag, ":rsp_valid"}, rsp_valid, onehot);
    chk({tag, ":rsp_err"}, rsp_err, we ? 1'b0 : t.exp_err);
    if (!we) chk({tag, ":rsp_rdata"}, rsp_rdata, t.exp_rdata);
    chk({tag, ":no_grant_in_done"}, req_ready, 0);
  endtask

  task automatic run_random(input int count);
    txn_t t;
    int   p;
    for (int k = 0; k < count; k++) begin
      t.vld = NP'($urandom_range(1, 3));
      t.we  = NP'($urandom_range(0, 3));
      for (int q = 0; q < NP; q++) begin
        t.addr[q]  = AW'($urandom());
        t.wdata[q] = $urandom();
        t.be[q]    = BW'($urandom());
      end
      t.dly   = ($urandom_range(0, 9) == 0) ? 0 : int'($urandom_range(1, 30));
      t.rdval = $urandom();
      t.exp_port = -1;
      for (int j = 1; j <= NP; j++) begin
        p = (m_rr + j) % NP;
        if (t.exp_port < 0 && t.vld[p]) t.exp_port = p;
      end
      t.exp_err   = (t.dly == 0);
      t.exp_rdata = (t.dly == 0) ? POISON : t.rdval;
      run_txn(t, $sformatf("rnd%0d", k));
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, cycle %0d", cyc);
    $fatal(1);
  end

  initial begin
    logic bad;
    logic seen;
    int   n;

    //       vld    we     a0        a1        d0            d1            b0       b1       dly rdval         port rdata         err
    tbl[0]  = mk(2'b11, 2'b00, 21'h00010, 21'h00011, 32'h0,        32'h0,        4'hF,    4'hF,    3,  32'hA5A50001, 0, 32'hA5A50001, 1'b0);
    tbl[1]  = mk(2'b11, 2'b11, 21'h00020, 21'h00021, 32'h01010101, 32'h02020202, 4'hF,    4'hF,    0,  32'h0,        1, 32'h0,        1'b0);
    tbl[2]  = mk(2'b11, 2'b10, 21'h00030, 21'h00031, 32'h0,        32'h03030303, 4'hF,    4'b0110, 1,  32'h5A5A0003, 0, 32'h5A5A0003, 1'b0);
    tbl[3]  = mk(2'b11, 2'b10, 21'h00040, 21'h00041, 32'h0,        32'h04040404, 4'hF,    4'b0110, 0,  32'h0,        1, 32'h0,        1'b0);
    tbl[4]  = mk(2'b10, 2'b00, 21'h1FFFFF, 21'h00123, 32'h0,       32'h0,        4'hF,    4'hF,    6,  32'hCAFEF00D, 1, 32'hCAFEF00D, 1'b0);
    tbl[5]  = mk(2'b01, 2'b01, 21'h00050, 21'h0,     32'h11223344, 32'h0,        4'b0011, 4'hF,    0,  32'h0,        0, 32'h0,        1'b0);
    tbl[6]  = mk(2'b01, 2'b00, 21'h1FFFFF, 21'h0,    32'h0,        32'h0,        4'hF,    4'hF,    255, 32'h0BADC0DE, 0, 32'h0BADC0DE, 1'b0);
    tbl[7]  = mk(2'b10, 2'b10, 21'h0,     21'h00077, 32'h0,        32'hFFEEDDCC, 4'hF,    4'b1000, 0,  32'h0,        1, 32'h0,        1'b0);
    tbl[8]  = mk(2'b01, 2'b00, 21'h00099, 21'h0,     32'h0,        32'h0,        4'hF,    4'hF,    0,  32'h0,        0, POISON,       1'b1);
    tbl[9]  = mk(2'b01, 2'b00, 21'h000AA, 21'h0,     32'h0,        32'h0,        4'hF,    4'hF,    2,  32'h600DF00D, 0, 32'h600DF00D, 1'b0);
    tbl[10] = mk(2'b10, 2'b00, 21'h0,     21'h00055, 32'h0,        32'h0,        4'hF,    4'hF,    0,  32'h0,        1, 32'h0,        1'b0);

    reset = 1'b1; mem_calib = 1'b0; mem_rd_valid = 1'b0; mem_rd_data = '0;
    req_valid = '0; req_we = '0; req_addr = '0; req_wdata = '0; req_be = '0;
    repeat (3) step();
    #1;
    chk_reset("reset");

    // Requests while calibration is pending must never be accepted.
    reset = 1'b0;
    req_valid = 2'b11;
    bad = 1'b0;
    for (int k = 0; k < 50; k++) begin
      step(); #1;
      if (req_ready != '0) bad = 1'b1;
    end
    chk("no_grant_uncalibrated", bad, 0);

    mem_calib = 1'b1;
    for (int i = 0; i < 9; i++) run_txn(tbl[i], $sformatf("row%0d", i));

    // Late read data after a timeout must not produce a response.
    seen = 1'b0;
    for (int k = 1; k <= 15; k++) begin
      step();
      mem_rd_valid = (k == 10);
      mem_rd_data  = 32'h12345678;
      #1;
      if (rsp_valid != '0 || req_ready != '0 || mem_cmd_en) seen = 1'b1;
    end
    mem_rd_valid = 1'b0;
    chk("late_valid_quiet", seen, 0);
    chk("late_valid_rdata", rsp_rdata, POISON);
    chk("late_valid_err", rsp_err, 1);

    // Calibration loss in IDLE sends the block back to INIT for a cycle.
    mem_calib = 1'b0;
    req_valid = 2'b01; req_we = 2'b00;
    #1;
    chk("calib_drop_ready", req_ready, 0);
    step();
    mem_calib = 1'b1;
    #1;
    chk("calib_drop_init_ready", req_ready, 0);
    run_txn(tbl[9], "after_calib");

    run_random(40);

    // Reset during RD_WAIT abandons the read silently.
    req_valid = tbl[10].vld; req_we = tbl[10].we; req_addr = tbl[10].addr;
    #1;
    n = 0;
    while (req_ready == '0 && n < 50) begin
      step(); #1; n++;
    end
    chk("midrst:grant", req_ready, 2'b10);
    step();
    req_valid = '0;
    step(); step();
    reset = 1'b1;
    step();
    #1;
    chk_reset("midrst");
    reset = 1'b0;
    seen = 1'b0;
    for (int k = 0; k < 20; k++) begin
      step();
      mem_rd_valid = (k == 3);
      mem_rd_data  = 32'h87654321;
      #1;
      if (rsp_valid != '0 || mem_cmd_en) seen = 1'b1;
    end
    mem_rd_valid = 1'b0;
    chk("midrst:quiet", seen, 0);
    chk("midrst:rdata", rsp_rdata, POISON);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/psram_port_arbiter.md
Name: psram_port_arbiter

Overview:
- Parametrised successor of the single-channel PSRAM data controller.
- Arbitrates NUM_PORTS CPU-side request ports (e.g. port 0 instruction fetch, port 1 load/store) onto one PSRAM user channel using round-robin.
- Issues read/write commands with byte masks, returns read data or write acknowledge to the granted port, and bounds every read with a timeout.
- Sits between the core's memory stage and the PSRAM interface user port; the whole block runs in the PSRAM user-clock domain.

Parameters:
- NUM_PORTS, 2, number of requesting ports (1..4).
- ADDR_WIDTH, 21, PSRAM word address width.
- DATA_WIDTH, 32, data width; DATA_WIDTH/8 byte lanes.
- WRITE_CYCLES, 14, cycles after a write command before the channel is free.
- RD_TIMEOUT, 255, maximum cycles waited for mem_rd_valid (8-bit counter).

Ports:
- clk  in  1  clock (PSRAM user clock).
- reset  in  1  synchronous, active-high.
- req_valid  in  NUM_PORTS  per-port request.
- req_we  in  NUM_PORTS  1 = write, 0 = read.
- req_addr  in  NUM_PORTS*ADDR_WIDTH  flattened; port p at [p*AW +: AW].
- req_wdata  in  NUM_PORTS*DATA_WIDTH  flattened write data.
- req_be  in  NUM_PORTS*DATA_WIDTH/8  flattened byte enables, 1 = write lane.
- req_ready  out  NUM_PORTS  one-hot accept strobe.
- rsp_valid  out  NUM_PORTS  one-hot, 1-cycle completion pulse.
- rsp_rdata  out  DATA_WIDTH  read data, valid with rsp_valid.
- rsp_err  out  1  timeout flag, valid with rsp_valid.
- mem_calib  in  1  PSRAM init_calib.
- mem_cmd  out  1  1 = write, 0 = read.
- mem_cmd_en  out  1  command strobe.
- mem_addr  out  ADDR_WIDTH  command address.
- mem_wr_data  out  DATA_WIDTH  write data.
- mem_data_mask  out  DATA_WIDTH/8  1 = lane masked.
- mem_rd_data  in  DATA_WIDTH  read data.
- mem_rd_valid  in  1  read data strobe.

Behaviour:
- Reset (synchronous, active-high):
  - state = INIT, rr pointer = NUM_PORTS-1.
  - req_ready = 0, rsp_valid = 0, rsp_err = 0, rsp_rdata = 32'hDEADBEEF.
  - mem_cmd_en = 0, mem_cmd = 0, mem_addr = 0, mem_wr_data = 0, mem_data_mask = all 1s.
  - Reset mid-transaction abandons it with no rsp_valid; later mem_rd_valid is ignored.
- INIT: outputs idle; go to IDLE on the first cycle mem_calib = 1.
- IDLE:
  - Grant goes to the first port with req_valid set, searching from rr+1 upward with wrap modulo NUM_PORTS.
  - req_ready[grant] = 1 combinationally in the same cycle; this is the accept cycle T.
  - At T, latch the port index, we, addr, wdata and ~be, and set rr = grant.
  - No request: stay in IDLE, req_ready = 0.
  - mem_calib dropping in IDLE returns the block to INIT.
- ISSUE (T+1):
  - mem_cmd_en = 1 for exactly one cycle, with mem_cmd = we and mem_addr = latched addr.
  - Write: mem_wr_data = wdata, mem_data_mask = ~be.
  - Read: mem_data_mask = 0.
  - Go to RD_WAIT for a read, WR_HOLD for a write.
- RD_WAIT:
  - cmd_en = 0; the counter increments each cycle.
  - When mem_rd_valid = 1, capture mem_rd_data into rsp_rdata and go to DONE with err = 0.
  - If the counter reaches RD_TIMEOUT with no valid, go to DONE with err = 1 and rsp_rdata = 32'hDEADBEEF.
  - mem_rd_valid arriving on the timeout cycle counts as success (valid wins).
- WR_HOLD:
  - mem_data_mask = all 1s; the counter counts 1..WRITE_CYCLES.
  - At WRITE_CYCLES, go to DONE.
- DONE:
  - rsp_valid[port] = 1 for one cycle; rsp_err is meaningful for reads only and is 0 for writes.
  - Go to IDLE.
  - A new grant may occur on the cycle after DONE at the earliest.
- Latency:
  - Read: rsp_valid 2 cycles after mem_rd_valid relative to T+1 issue, i.e. mem_rd_valid at cycle V gives rsp_valid at V+1.
  - Write: rsp_valid at T+2+WRITE_CYCLES.
- mem_rd_valid outside RD_WAIT is ignored.
- Requesters must hold req_valid and payload stable until req_ready.
- Only one transaction is outstanding at a time.

Test Plan:
- Read: hold reset 3 cycles, mem_calib = 1; port 1 reads 0x00123; model returns 0xCAFEF00D 6 cycles after cmd_en -> mem_cmd = 0 with mem_addr = 0x00123 at T+1, rsp_valid = 2'b10 with rdata 0xCAFEF00D and err 0 one cycle after mem_rd_valid.
- Masked write: port 0 writes 0x11223344 with be 4'b0011 -> one cmd_en pulse with mem_cmd = 1 and mask 4'b1100, then mask 4'hF; rsp_valid = 2'b01 at T+16 (WRITE_CYCLES = 14).
- Fairness: both ports request continuously from reset (rr = 1) -> grants alternate 0, 1, 0, 1 over 4 transactions and no port is granted twice in a row.
- Timeout: read with no mem_rd_valid -> rsp_valid after 255 wait cycles with err = 1 and rdata 0xDEADBEEF; a valid arriving 10 cycles later is ignored and nothing changes in IDLE.
- Calib/reset: with mem_calib = 0 and req_valid = 1, req_ready stays 0 for 50 cycles. Then calib = 1, grant, and assert reset during RD_WAIT -> no rsp_valid, outputs back at reset values the next cycle, and the late mem_rd_valid is ignored.
